module_gpio_event: RTL and testbench

- Input-direction companion to the GPIO port block: samples external input pins, synchronises and debounces them, detects rising/falling edges, latches pending flags and raises a level interrupt to the core.
- Sits on the same memory-mapped peripheral register interface as the GPIO block: 3-bit register select, write enable, 32-bit data in/out.

---
 rtl/module_gpio_event.sv | 145 ++++++++++++++
 tb/tb_module_gpio_event.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/module_gpio_event.sv
`default_nettype none
// ============================================================================
// Module   : module_gpio_event
// Brief    : Input-pin event block: synchroniser, per-pin debounce, edge
//            detect, W1C pending flags and registered level interrupt.
//            Optional TICK/TSTAMP counters under GPIO_EVENT_TIMESTAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module module_gpio_event #(
  parameter int WIDTH = 8,
  parameter int DBW   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       reg_sel,
  input  logic             we,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  input  logic [WIDTH-1:0] pins,
  output logic             irq
);

  localparam logic [2:0] C_SEL_RISE_EN  = 3'd0;
  localparam logic [2:0] C_SEL_FALL_EN  = 3'd1;
  localparam logic [2:0] C_SEL_PENDING  = 3'd2;
  localparam logic [2:0] C_SEL_IRQ_EN   = 3'd3;
  localparam logic [2:0] C_SEL_STATE    = 3'd4;
  localparam logic [2:0] C_SEL_DEBOUNCE = 3'd5;
  localparam logic [2:0] C_SEL_TSTAMP   = 3'd6;
  localparam logic [2:0] C_SEL_TICK     = 3'd7;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_irq_en;
  logic [DBW-1:0]   r_debounce;
  logic             r_irq;

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_fire;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic             w_unused;

  assign w_unused = ^din;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= pins;
      r_s2 <= r_s1;
    end
  end

  // Compare precedes increment, so the counter can never pass the threshold.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      logic [DBW-1:0] r_cnt;
      logic           r_stable_bit;

      assign w_fire[gi]   = (r_s2[gi] != r_stable_bit) && (r_cnt == r_debounce);
      assign w_stable[gi] = r_stable_bit;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_cnt        <= '0;
          r_stable_bit <= 1'b0;
        end else if (r_s2[gi] == r_stable_bit) begin
          r_cnt <= '0;
        end else if (r_cnt == r_debounce) begin
          r_stable_bit <= r_s2[gi];
          r_cnt        <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  endgenerate

  assign w_set = (w_fire & r_s2 & r_rise_en) | (w_fire & ~r_s2 & r_fall_en);
  assign w_clr = (we && reg_sel == C_SEL_PENDING) ? din[WIDTH-1:0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise_en  <= '0;
      r_fall_en  <= '0;
      r_irq_en   <= '0;
      r_debounce <= '0;
      r_pending  <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (we && reg_sel == C_SEL_RISE_EN)  r_rise_en  <= din[WIDTH-1:0];
      if (we && reg_sel == C_SEL_FALL_EN)  r_fall_en  <= din[WIDTH-1:0];
      if (we && reg_sel == C_SEL_IRQ_EN)   r_irq_en   <= din[WIDTH-1:0];
      if (we && reg_sel == C_SEL_DEBOUNCE) r_debounce <= din[DBW-1:0];
      // Set has priority over a same-cycle write-1-to-clear.
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_irq     <= |(r_pending & r_irq_en);
    end
  end

  assign irq = r_irq;

`ifdef GPIO_EVENT_TIMESTAMP_EN
  logic [31:0] r_tick;
  logic [31:0] r_tstamp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick   <= '0;
      r_tstamp <= '0;
    end else begin
      r_tick <= r_tick + 32'd1;
      if (|(w_set & ~r_pending)) r_tstamp <= r_tick;
    end
  end
`endif

  always_comb begin
    dout = '0;
    case (reg_sel)
      C_SEL_RISE_EN:  dout[WIDTH-1:0] = r_rise_en;
      C_SEL_FALL_EN:  dout[WIDTH-1:0] = r_fall_en;
      C_SEL_PENDING:  dout[WIDTH-1:0] = r_pending;
      C_SEL_IRQ_EN:   dout[WIDTH-1:0] = r_irq_en;
      C_SEL_STATE:    dout[WIDTH-1:0] = w_stable;
      C_SEL_DEBOUNCE: dout[DBW-1:0]   = r_debounce;
`ifdef GPIO_EVENT_TIMESTAMP_EN
      C_SEL_TSTAMP:   dout            = r_tstamp;
      C_SEL_TICK:     dout            = r_tick;
`else
      C_SEL_TSTAMP:   dout            = '0;
      C_SEL_TICK:     dout            = '0;
`endif
      default:        dout            = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_module_gpio_event.sv
`default_nettype none
// ============================================================================
// Module   : tb_module_gpio_event
// Brief    : Directed self-checking bench for module_gpio_event.
// Revision : 1.0 - initial release
// ============================================================================
module tb_module_gpio_event;

  logic        clk;
  logic        reset;
  logic [2:0]  reg_sel;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic [7:0]  pins;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  module_gpio_event #(.WIDTH(8), .DBW(16)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .reg_sel (reg_sel),
    .we      (we),
    .din     (din),
    .dout    (dout),
    .pins    (pins),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All tasks are entered at a falling edge and leave at a falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic write_reg(input logic [2:0] sel, input logic [31:0] data);
    reg_sel = sel;
    din     = data;
    we      = 1'b1;
    @(negedge clk);
    we      = 1'b0;
    din     = '0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] sel, input logic [31:0] exp);
    reg_sel = sel;
    #1;
    check(tag, dout, exp);
  endtask

  logic [31:0] t0;
  logic [31:0] t1;

  initial begin
    reset = 1'b1; reg_sel = '0; we = 1'b0; din = '0; pins = '0;
    step(2);
    reset = 1'b0;

    // Reset state: every select reads zero, no interrupt.
    for (int s = 0; s < 8; s++) read_chk($sformatf("reset_rd%0d", s), 3'(s), 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    // Rising edge on pin 0 with zero debounce.
    write_reg(3'd5, 32'h0);
    write_reg(3'd0, 32'h01);
    write_reg(3'd3, 32'h01);
    pins = 8'h01;
    step(2);
    read_chk("rise_pend_early", 3'd2, 32'h00);
    step(1);
    read_chk("rise_pend", 3'd2, 32'h01);
    check("rise_irq_lag", {31'b0, irq}, 32'h0);
    step(1);
    check("rise_irq", {31'b0, irq}, 32'h1);
    read_chk("rise_state", 3'd4, 32'h01);
    write_reg(3'd2, 32'h01);
    read_chk("rise_w1c", 3'd2, 32'h00);
    check("rise_irq_hold", {31'b0, irq}, 32'h1);
    step(1);
    check("rise_irq_clr", {31'b0, irq}, 32'h0);

    // Debounce threshold 4: short pulse filtered, long hold accepted.
    write_reg(3'd5, 32'h4);
    read_chk("db_reg", 3'd5, 32'h4);
    pins = 8'h09;
    step(3);
    pins = 8'h01;
    step(10);
    read_chk("db_glitch_state", 3'd4, 32'h01);
    read_chk("db_glitch_pend", 3'd2, 32'h00);
    pins = 8'h09;
    step(6);
    read_chk("db_hold_early", 3'd4, 32'h01);
    step(1);
    read_chk("db_hold_state", 3'd4, 32'h09);
    read_chk("db_hold_pend", 3'd2, 32'h00);

    // W1C and set-over-clear priority.
    write_reg(3'd5, 32'h0);
    write_reg(3'd0, 32'h03);
    write_reg(3'd1, 32'h02);
    write_reg(3'd3, 32'h00);
    pins = 8'h08;
    step(4);
    pins = 8'h0B;
    step(3);
    read_chk("w1c_pend3", 3'd2, 32'h03);
    write_reg(3'd2, 32'h01);
    read_chk("w1c_clr0", 3'd2, 32'h02);
    pins = 8'h09;
    step(2);
    write_reg(3'd2, 32'h02);
    read_chk("w1c_set_wins", 3'd2, 32'h02);
    read_chk("w1c_state", 3'd4, 32'h09);
    write_reg(3'd2, 32'h03);
    read_chk("w1c_clear_all", 3'd2, 32'h00);

    // Interrupt masking on pin 2 falling edge.
    write_reg(3'd1, 32'h04);
    pins = 8'h0D;
    step(4);
    read_chk("mask_rise_ignored", 3'd2, 32'h00);
    pins = 8'h09;
    step(4);
    read_chk("mask_pend", 3'd2, 32'h04);
    check("mask_irq_off", {31'b0, irq}, 32'h0);
    write_reg(3'd3, 32'h04);
    check("mask_irq_lag", {31'b0, irq}, 32'h0);
    step(1);
    check("mask_irq_on", {31'b0, irq}, 32'h1);
    write_reg(3'd2, 32'h04);
    check("mask_irq_hold", {31'b0, irq}, 32'h1);
    step(1);
    check("mask_irq_clr", {31'b0, irq}, 32'h0);

`ifdef GPIO_EVENT_TIMESTAMP_EN
    reg_sel = 3'd7; #1; t0 = dout;
    step(10);
    reg_sel = 3'd7; #1; t1 = dout;
    check("tick_delta", t1 - t0, 32'd10);
    pins = 8'h08;
    step(4);
    pins = 8'h09;
    step(2);
    reg_sel = 3'd7; #1; t0 = dout;
    step(1);
    read_chk("tstamp", 3'd6, t0);
`else
    t0 = '0; t1 = '0;
    read_chk("tstamp_absent", 3'd6, 32'h0);
    read_chk("tick_absent", 3'd7, 32'h0);
`endif

    // Asynchronous reset while irq is high.
    pins = 8'h0D;
    step(4);
    pins = 8'h09;
    step(5);
    check("arst_pre_irq", {31'b0, irq}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("arst_irq", {31'b0, irq}, 32'h0);
    read_chk("arst_pend", 3'd2, 32'h0);
    read_chk("arst_state", 3'd4, 32'h0);
    step(1);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
